// File: rtl/randseq_parser.sv
// Purpose: recognizes "op operand DONE" token sentences and folds each good one into a signed running accumulator.
// Latency: the result or error from a token accepted in cycle N is visible in cycle N+1.
// Backpressure: tok_ready is low while a result is pending; it rises the cycle after res_valid && res_ready.
module randseq_parser #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tok_valid,
  output logic             tok_ready,
  input  logic [2:0]       tok,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_op,
  output logic [1:0]       res_operand,
  output logic [ACC_W-1:0] res_acc,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] sent_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [2:0] TOK_ADD   = 3'd1;
  localparam logic [2:0] TOK_SUB   = 3'd2;
  localparam logic [2:0] TOK_ONE   = 3'd3;
  localparam logic [2:0] TOK_TWO   = 3'd4;
  localparam logic [2:0] TOK_THREE = 3'd5;
  localparam logic [2:0] TOK_DONE  = 3'd6;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_UNEXP   = 2'd1;
  localparam logic [1:0] ERR_ILLEGAL = 2'd2;

  typedef enum logic [1:0] {
    S_OP,
    S_ARG,
    S_END,
    S_SKIP
  } state_t;

  // One sentence worth of decoded fields: operation and operand value 1..3.
  typedef struct packed {
    logic       op;
    logic [1:0] operand;
  } sentence_t;

  state_t           state;
  sentence_t        cur;
  sentence_t        res_q;
  logic [ACC_W-1:0] acc_q;

  logic             tok_fire;
  logic             is_op;
  logic             is_arg;
  logic             is_done;
  logic             is_illegal;
  logic             tok_expected;
  logic [1:0]       tok_err;
  logic [1:0]       arg_val;
  logic [ACC_W-1:0] arg_ext;
  logic [ACC_W-1:0] acc_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Ready depends only on the registered result flag, never on tok_valid or res_ready.
  assign tok_ready = !res_valid;
  assign tok_fire  = tok_valid && tok_ready;

  // The accumulator only changes when a result is loaded, so it doubles as res_acc.
  assign res_acc     = acc_q;
  assign res_op      = res_q.op;
  assign res_operand = res_q.operand;

  // Operand tokens ONE/TWO/THREE map to values 1/2/3; zero-extended for the add/sub.
  assign arg_val  = 2'(tok - 3'd2);
  assign arg_ext  = ACC_W'(cur.operand);
  assign acc_next = cur.op ? (acc_q - arg_ext) : (acc_q + arg_ext);

  // Classify the incoming token and decide which error (if any) it raises in the current state.
  always_comb begin
    is_op        = (tok == TOK_ADD) || (tok == TOK_SUB);
    is_arg       = (tok == TOK_ONE) || (tok == TOK_TWO) || (tok == TOK_THREE);
    is_done      = (tok == TOK_DONE);
    is_illegal   = !(is_op || is_arg || is_done);
    tok_expected = 1'b0;
    tok_err      = ERR_NONE;
    case (state)
      S_OP:    tok_expected = is_op;
      S_ARG:   tok_expected = is_arg;
      S_END:   tok_expected = is_done;
      default: tok_expected = 1'b1;
    endcase
    if (!tok_expected) begin
      tok_err = is_illegal ? ERR_ILLEGAL : ERR_UNEXP;
    end
  end

  // Sentence FSM with accumulator, result handshake, error pulse and saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_OP;
      cur       <= '0;
      res_q     <= '0;
      acc_q     <= '0;
      res_valid <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
      sent_cnt  <= '0;
      err_cnt   <= '0;
    end else begin
      err      <= 1'b0;
      err_code <= ERR_NONE;
      if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
      if (tok_fire) begin
        if (tok_err != ERR_NONE) begin
          err      <= 1'b1;
          err_code <= tok_err;
          err_cnt  <= sat_inc(err_cnt);
        end
        case (state)
          S_OP: begin
            if (is_op) begin
              cur.op <= (tok == TOK_SUB);
              state  <= S_ARG;
            end else if (!is_done) begin
              state <= S_SKIP;
            end
          end
          S_ARG: begin
            if (is_arg) begin
              cur.operand <= arg_val;
              state       <= S_END;
            end else if (is_done) begin
              state <= S_OP;
            end else begin
              state <= S_SKIP;
            end
          end
          S_END: begin
            if (is_done) begin
              acc_q     <= acc_next;
              res_q     <= cur;
              res_valid <= 1'b1;
              sent_cnt  <= sat_inc(sent_cnt);
              state     <= S_OP;
            end else begin
              state <= S_SKIP;
            end
          end
          default: begin
            // Resync: drop everything up to and including the next DONE.
            if (is_done) begin
              state <= S_OP;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_randseq_parser.sv
// Purpose: self-checking bench for randseq_parser, directed scenarios plus randomized traffic against a grammar model.
// Latency: outputs are sampled on the falling edge, half a cycle after the rising edge that produced them.
// Backpressure: res_ready is toggled in the backpressure and random scenarios.
module tb_randseq_parser;

  localparam logic [2:0] ADD   = 3'd1;
  localparam logic [2:0] SUB   = 3'd2;
  localparam logic [2:0] ONE   = 3'd3;
  localparam logic [2:0] TWO   = 3'd4;
  localparam logic [2:0] THREE = 3'd5;
  localparam logic [2:0] DONE  = 3'd6;
  localparam logic [2:0] BAD7  = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic        tok_valid, tok_ready;
  logic [2:0]  tok;
  logic        res_valid, res_ready, res_op;
  logic [1:0]  res_operand;
  logic [15:0] res_acc;
  logic        err;
  logic [1:0]  err_code;
  logic [7:0]  sent_cnt, err_cnt;

  logic        t2_valid, t2_ready;
  logic [2:0]  t2_tok;
  logic        r2_valid, r2_ready, r2_op;
  logic [1:0]  r2_operand;
  logic [15:0] r2_acc;
  logic        e2;
  logic [1:0]  e2_code;
  logic [1:0]  s2_cnt, e2_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  randseq_parser #(.ACC_W(16), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok(tok),
    .res_valid(res_valid), .res_ready(res_ready), .res_op(res_op),
    .res_operand(res_operand), .res_acc(res_acc),
    .err(err), .err_code(err_code), .sent_cnt(sent_cnt), .err_cnt(err_cnt)
  );

  randseq_parser #(.ACC_W(16), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .tok_valid(t2_valid), .tok_ready(t2_ready), .tok(t2_tok),
    .res_valid(r2_valid), .res_ready(r2_ready), .res_op(r2_op),
    .res_operand(r2_operand), .res_acc(r2_acc),
    .err(e2), .err_code(e2_code), .sent_cnt(s2_cnt), .err_cnt(e2_cnt)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; tok_valid = 1'b0; t2_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives three tokens on consecutive cycles; returns in the cycle after the last one is accepted.
  task automatic send3(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
    @(negedge clk); tok_valid = 1'b1; tok = a;
    @(negedge clk); tok = b;
    @(negedge clk); tok = c;
    @(negedge clk); tok_valid = 1'b0;
  endtask

  function automatic bit fits(input int pos, input logic [2:0] t);
    case (pos)
      0:       return (t == ADD) || (t == SUB);
      1:       return (t == ONE) || (t == TWO) || (t == THREE);
      default: return (t == DONE);
    endcase
  endfunction

  task automatic test_reset();
    res_ready = 1'b1;
    do_reset();
    @(negedge clk);
    n_cmp++; if (tok_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_tok_ready got %0h want 1", tok_ready); end
    n_cmp++; if (res_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_res_valid got %0h want 0", res_valid); end
    n_cmp++; if (res_op !== 1'b0)      begin n_fail++; $display("FAIL reset_res_op got %0h want 0", res_op); end
    n_cmp++; if (res_operand !== 2'd0) begin n_fail++; $display("FAIL reset_res_operand got %0h want 0", res_operand); end
    n_cmp++; if (res_acc !== 16'd0)    begin n_fail++; $display("FAIL reset_res_acc got %0h want 0", res_acc); end
    n_cmp++; if (err !== 1'b0)         begin n_fail++; $display("FAIL reset_err got %0h want 0", err); end
    n_cmp++; if (err_code !== 2'd0)    begin n_fail++; $display("FAIL reset_err_code got %0h want 0", err_code); end
    n_cmp++; if (sent_cnt !== 8'd0)    begin n_fail++; $display("FAIL reset_sent_cnt got %0h want 0", sent_cnt); end
    n_cmp++; if (err_cnt !== 8'd0)     begin n_fail++; $display("FAIL reset_err_cnt got %0h want 0", err_cnt); end
    n_cmp++; if (e2_cnt !== 2'd0)      begin n_fail++; $display("FAIL reset_err_cnt2 got %0h want 0", e2_cnt); end
  endtask

  task automatic test_basic();
    res_ready = 1'b1;
    do_reset();
    send3(ADD, TWO, DONE);
    n_cmp++; if (res_valid !== 1'b1)   begin n_fail++; $display("FAIL basic_res_valid got %0h want 1", res_valid); end
    n_cmp++; if (res_op !== 1'b0)      begin n_fail++; $display("FAIL basic_res_op got %0h want 0", res_op); end
    n_cmp++; if (res_operand !== 2'd2) begin n_fail++; $display("FAIL basic_res_operand got %0h want 2", res_operand); end
    n_cmp++; if (res_acc !== 16'd2)    begin n_fail++; $display("FAIL basic_res_acc got %0h want 2", res_acc); end
    n_cmp++; if (sent_cnt !== 8'd1)    begin n_fail++; $display("FAIL basic_sent_cnt got %0h want 1", sent_cnt); end
    n_cmp++; if (err !== 1'b0)         begin n_fail++; $display("FAIL basic_err got %0h want 0", err); end
    n_cmp++; if (tok_ready !== 1'b0)   begin n_fail++; $display("FAIL basic_tok_ready_low got %0h want 0", tok_ready); end
    @(negedge clk);
    n_cmp++; if (res_valid !== 1'b0)   begin n_fail++; $display("FAIL basic_res_valid_drop got %0h want 0", res_valid); end
    n_cmp++; if (tok_ready !== 1'b1)   begin n_fail++; $display("FAIL basic_tok_ready_back got %0h want 1", tok_ready); end
    send3(SUB, THREE, DONE);
    n_cmp++; if (res_acc !== 16'hFFFF) begin n_fail++; $display("FAIL basic_sub_acc got %0h want ffff", res_acc); end
    n_cmp++; if (res_op !== 1'b1)      begin n_fail++; $display("FAIL basic_sub_op got %0h want 1", res_op); end
    n_cmp++; if (sent_cnt !== 8'd2)    begin n_fail++; $display("FAIL basic_sub_sent got %0h want 2", sent_cnt); end
    @(negedge clk);
    send3(ADD, ONE, DONE);
    n_cmp++; if (res_acc !== 16'd0)    begin n_fail++; $display("FAIL basic_wrap_acc got %0h want 0", res_acc); end
    n_cmp++; if (sent_cnt !== 8'd3)    begin n_fail++; $display("FAIL basic_wrap_sent got %0h want 3", sent_cnt); end
    n_cmp++; if (err_cnt !== 8'd0)     begin n_fail++; $display("FAIL basic_err_cnt got %0h want 0", err_cnt); end
    @(negedge clk);
  endtask

  task automatic test_error_resync();
    logic [2:0] seq [0:6];
    logic       exp_err;
    seq = '{ADD, ADD, ONE, DONE, SUB, ONE, DONE};
    res_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i > 0) begin
        exp_err = (i == 2);
        n_cmp++; if (err !== exp_err) begin n_fail++; $display("FAIL resync_err_step%0d got %0h want %0h", i, err, exp_err); end
        n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL resync_no_result_step%0d got %0h want 0", i, res_valid); end
        if (i == 2) begin
          n_cmp++; if (err_code !== 2'd1) begin n_fail++; $display("FAIL resync_err_code got %0h want 1", err_code); end
        end
      end
      tok_valid = 1'b1;
      tok = seq[i];
    end
    @(negedge clk);
    tok_valid = 1'b0;
    n_cmp++; if (res_valid !== 1'b1)   begin n_fail++; $display("FAIL resync_res_valid got %0h want 1", res_valid); end
    n_cmp++; if (res_op !== 1'b1)      begin n_fail++; $display("FAIL resync_res_op got %0h want 1", res_op); end
    n_cmp++; if (res_acc !== 16'hFFFF) begin n_fail++; $display("FAIL resync_res_acc got %0h want ffff", res_acc); end
    n_cmp++; if (sent_cnt !== 8'd1)    begin n_fail++; $display("FAIL resync_sent_cnt got %0h want 1", sent_cnt); end
    n_cmp++; if (err_cnt !== 8'd1)     begin n_fail++; $display("FAIL resync_err_cnt got %0h want 1", err_cnt); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    res_ready = 1'b1;
    do_reset();
    res_ready = 1'b0;
    send3(ADD, THREE, DONE);
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (res_valid !== 1'b1)   begin n_fail++; $display("FAIL bp_res_valid_hold%0d got %0h want 1", k, res_valid); end
      n_cmp++; if (res_acc !== 16'd3)    begin n_fail++; $display("FAIL bp_res_acc_hold%0d got %0h want 3", k, res_acc); end
      n_cmp++; if (res_operand !== 2'd3) begin n_fail++; $display("FAIL bp_res_operand_hold%0d got %0h want 3", k, res_operand); end
      n_cmp++; if (tok_ready !== 1'b0)   begin n_fail++; $display("FAIL bp_tok_ready_hold%0d got %0h want 0", k, tok_ready); end
      tok_valid = 1'b1;
      tok = ADD;
      @(negedge clk);
    end
    n_cmp++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL bp_res_valid_last got %0h want 1", res_valid); end
    res_ready = 1'b1;
    tok_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL bp_res_valid_release got %0h want 0", res_valid); end
    n_cmp++; if (tok_ready !== 1'b1) begin n_fail++; $display("FAIL bp_tok_ready_release got %0h want 1", tok_ready); end
    n_cmp++; if (err_cnt !== 8'd0)   begin n_fail++; $display("FAIL bp_ignored_tokens_err got %0h want 0", err_cnt); end
    send3(SUB, ONE, DONE);
    n_cmp++; if (res_acc !== 16'd2)  begin n_fail++; $display("FAIL bp_next_acc got %0h want 2", res_acc); end
    n_cmp++; if (sent_cnt !== 8'd2)  begin n_fail++; $display("FAIL bp_next_sent got %0h want 2", sent_cnt); end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt;
    r2_ready = 1'b1;
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      t2_valid = 1'b1; t2_tok = BAD7;
      @(negedge clk);
      t2_tok = DONE;
      exp_cnt = (k > 3) ? 2'd3 : 2'(k);
      n_cmp++; if (e2 !== 1'b1)         begin n_fail++; $display("FAIL sat_err%0d got %0h want 1", k, e2); end
      n_cmp++; if (e2_code !== 2'd2)    begin n_fail++; $display("FAIL sat_err_code%0d got %0h want 2", k, e2_code); end
      n_cmp++; if (e2_cnt !== exp_cnt)  begin n_fail++; $display("FAIL sat_err_cnt%0d got %0h want %0h", k, e2_cnt, exp_cnt); end
      @(negedge clk);
      t2_valid = 1'b0;
      n_cmp++; if (e2 !== 1'b0)         begin n_fail++; $display("FAIL sat_done_silent%0d got %0h want 0", k, e2); end
      n_cmp++; if (r2_valid !== 1'b0)   begin n_fail++; $display("FAIL sat_no_result%0d got %0h want 0", k, r2_valid); end
    end
    n_cmp++; if (s2_cnt !== 2'd0) begin n_fail++; $display("FAIL sat_sent_cnt got %0h want 0", s2_cnt); end
  endtask

  task automatic test_reset_mid();
    res_ready = 1'b1;
    do_reset();
    @(negedge clk); tok_valid = 1'b1; tok = SUB;
    @(negedge clk); tok = TWO;
    @(negedge clk); tok_valid = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    n_cmp++; if (tok_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_tok_ready got %0h want 1", tok_ready); end
    n_cmp++; if (err_cnt !== 8'd0)   begin n_fail++; $display("FAIL midrst_err_cnt0 got %0h want 0", err_cnt); end
    tok_valid = 1'b1; tok = DONE;
    @(negedge clk); tok_valid = 1'b0;
    n_cmp++; if (err !== 1'b1)       begin n_fail++; $display("FAIL midrst_err got %0h want 1", err); end
    n_cmp++; if (err_code !== 2'd1)  begin n_fail++; $display("FAIL midrst_err_code got %0h want 1", err_code); end
    n_cmp++; if (err_cnt !== 8'd1)   begin n_fail++; $display("FAIL midrst_err_cnt got %0h want 1", err_cnt); end
    n_cmp++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_result got %0h want 0", res_valid); end
    n_cmp++; if (res_acc !== 16'd0)  begin n_fail++; $display("FAIL midrst_acc got %0h want 0", res_acc); end
    // Reset while a result is pending, colliding with both handshakes.
    res_ready = 1'b0;
    send3(ADD, ONE, DONE);
    n_cmp++; if (res_valid !== 1'b1) begin n_fail++; $display("FAIL pendrst_setup got %0h want 1", res_valid); end
    rst = 1'b1; res_ready = 1'b1; tok_valid = 1'b1; tok = ADD;
    @(negedge clk);
    rst = 1'b0; tok_valid = 1'b0;
    n_cmp++; if (res_valid !== 1'b0)   begin n_fail++; $display("FAIL pendrst_res_valid got %0h want 0", res_valid); end
    n_cmp++; if (res_acc !== 16'd0)    begin n_fail++; $display("FAIL pendrst_acc got %0h want 0", res_acc); end
    n_cmp++; if (res_operand !== 2'd0) begin n_fail++; $display("FAIL pendrst_operand got %0h want 0", res_operand); end
    n_cmp++; if (sent_cnt !== 8'd0)    begin n_fail++; $display("FAIL pendrst_sent got %0h want 0", sent_cnt); end
    send3(ADD, TWO, DONE);
    n_cmp++; if (res_acc !== 16'd2)    begin n_fail++; $display("FAIL pendrst_after_acc got %0h want 2", res_acc); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int         m_acc, m_racc, m_sent, m_errc, m_code, m_arg;
    bit         m_rv, m_op, m_err, bad, accepted;
    logic [2:0] seg[$];
    int         gen_pos;
    logic       tv, rr;
    logic [2:0] tk;
    res_ready = 1'b1;
    do_reset();
    m_acc = 0; m_racc = 0; m_sent = 0; m_errc = 0; m_code = 0; m_arg = 0;
    m_rv = 0; m_op = 0; m_err = 0; bad = 0; gen_pos = 0;
    seg.delete();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      n_cmp++; if (tok_ready !== !m_rv)             begin n_fail++; $display("FAIL rnd_tok_ready c%0d got %0h want %0h", c, tok_ready, !m_rv); end
      n_cmp++; if (res_valid !== m_rv)              begin n_fail++; $display("FAIL rnd_res_valid c%0d got %0h want %0h", c, res_valid, m_rv); end
      n_cmp++; if (res_op !== m_op)                 begin n_fail++; $display("FAIL rnd_res_op c%0d got %0h want %0h", c, res_op, m_op); end
      n_cmp++; if (res_operand !== m_arg[1:0])      begin n_fail++; $display("FAIL rnd_res_operand c%0d got %0h want %0h", c, res_operand, m_arg[1:0]); end
      n_cmp++; if (res_acc !== m_racc[15:0])        begin n_fail++; $display("FAIL rnd_res_acc c%0d got %0h want %0h", c, res_acc, m_racc[15:0]); end
      n_cmp++; if (err !== m_err)                   begin n_fail++; $display("FAIL rnd_err c%0d got %0h want %0h", c, err, m_err); end
      n_cmp++; if (err_code !== m_code[1:0])        begin n_fail++; $display("FAIL rnd_err_code c%0d got %0h want %0h", c, err_code, m_code[1:0]); end
      n_cmp++; if (sent_cnt !== m_sent[7:0])        begin n_fail++; $display("FAIL rnd_sent_cnt c%0d got %0h want %0h", c, sent_cnt, m_sent[7:0]); end
      n_cmp++; if (err_cnt !== m_errc[7:0])         begin n_fail++; $display("FAIL rnd_err_cnt c%0d got %0h want %0h", c, err_cnt, m_errc[7:0]); end

      tv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 9) < 8) begin
        case (gen_pos)
          0:       tk = 3'($urandom_range(1, 2));
          1:       tk = 3'($urandom_range(3, 5));
          default: tk = DONE;
        endcase
      end else begin
        tk = 3'($urandom_range(0, 7));
      end
      tok_valid = tv; tok = tk; res_ready = rr;

      // Reference: grammar match on the tokens collected since the last sentence boundary.
      accepted = tv && !m_rv;
      m_err = 0; m_code = 0;
      if (m_rv && rr) m_rv = 0;
      if (accepted) begin
        gen_pos = (tk == DONE) ? 0 : ((gen_pos < 2) ? gen_pos + 1 : 2);
        if (bad) begin
          if (tk == DONE) bad = 0;
        end else if (fits(seg.size(), tk)) begin
          seg.push_back(tk);
          if (seg.size() == 3) begin
            m_op  = (seg[0] == SUB);
            m_arg = int'(seg[1]) - 2;
            m_acc = (m_op ? (m_acc - m_arg) : (m_acc + m_arg)) & 32'hFFFF;
            m_racc = m_acc;
            m_rv = 1;
            if (m_sent < 255) m_sent++;
            seg.delete();
          end
        end else begin
          m_err  = 1;
          m_code = (tk == 3'd0 || tk == 3'd7) ? 2 : 1;
          if (m_errc < 255) m_errc++;
          seg.delete();
          bad = (tk != DONE);
        end
      end
    end
    @(negedge clk);
    tok_valid = 1'b0;
    res_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    tok_valid = 1'b0; tok = 3'd0; res_ready = 1'b1;
    t2_valid = 1'b0; t2_tok = 3'd0; r2_ready = 1'b1;
    test_reset();
    test_basic();
    test_error_resync();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
